// File: rtl/cpu_bus_arbiter_pkg.sv
// cpu_bus_arbiter_pkg: bus widths, arbiter state and latched memory-request types
package cpu_bus_arbiter_pkg;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY} arb_state_t;
  typedef struct packed {
    logic [AW-1:0] address;
    logic [DW-1:0] data_wr;
    logic [MW-1:0] mask;
    logic          read;
    logic          write;
  } mem_port_req_t;
endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// cpu_bus_arbiter_if: one CPU bus master (address/data/mask/read/write out, stall/data_rd back)
interface cpu_bus_arbiter_if;
  import cpu_bus_arbiter_pkg::*;
  logic [AW-1:0] address;
  logic [DW-1:0] data_wr;
  logic [MW-1:0] mask;
  logic          read;
  logic          write;
  logic          stall;
  logic [DW-1:0] data_rd;
  modport master(output address, data_wr, mask, read, write, input stall, data_rd);
  modport slave(input address, data_wr, mask, read, write, output stall, data_rd);
endinterface

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: shares one memory port between ibus (fetch) and dbus (data, priority)
// ports: clk, rst (async high); ibus/dbus slave buses; mem_* registered request to memory,
// mem_data_rd/mem_ready from memory; bus_timeout pulses when a transfer is abandoned
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  cpu_bus_arbiter_if.slave ibus,
  cpu_bus_arbiter_if.slave dbus,
  output logic [AW-1:0]   mem_address,
  output logic            mem_read,
  output logic            mem_write,
  output logic [DW-1:0]   mem_data_wr,
  output logic [MW-1:0]   mem_mask,
  input  logic [DW-1:0]   mem_data_rd,
  input  logic            mem_ready,
  output logic            bus_timeout
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  arb_state_t    state, state_nx;
  mem_port_req_t req, req_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          busy, d_req, i_req, hit, done;
  assign d_req = dbus.read | dbus.write;
  assign i_req = ibus.read | ibus.write;
  assign busy  = state != IDLE;
  assign hit   = TIMEOUT_CYCLES != 0 && busy && cnt == CW'(TIMEOUT_CYCLES);
  assign done  = busy & (mem_ready | hit);
  // a ready arriving on the timeout cycle still completes the transfer normally
  assign bus_timeout = hit & ~mem_ready;
  always_comb begin
    state_nx = state;
    req_nx   = req;
    cnt_nx   = !busy ? '0 : cnt == '1 ? cnt : cnt + CW'(1);
    if (done) begin
      state_nx    = IDLE;
      req_nx.read  = 1'b0;
      req_nx.write = 1'b0;
      cnt_nx      = '0;
    end else if (!busy && d_req) begin
      state_nx = D_BUSY;
      req_nx   = '{dbus.address, dbus.data_wr, dbus.mask, dbus.read, dbus.write};
    end else if (!busy && i_req) begin
      state_nx = I_BUSY;
      req_nx   = '{ibus.address, ibus.data_wr, 4'hF, 1'b1, 1'b0};
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      req   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      req   <= req_nx;
      cnt   <= cnt_nx;
    end
  assign mem_address = req.address;
  assign mem_data_wr = req.data_wr;
  assign mem_mask    = req.mask;
  assign mem_read    = req.read;
  assign mem_write   = req.write;
  // stalls are forced low while reset is held so an aborted transfer releases nobody falsely stalled
  assign dbus.stall   = d_req & ~rst & ~(state == D_BUSY & done);
  assign ibus.stall   = i_req & ~rst & ~(state == I_BUSY & done);
  assign dbus.data_rd = (state == D_BUSY && mem_ready && req.read) ? mem_data_rd : '0;
  assign ibus.data_rd = (state == I_BUSY && mem_ready && req.read) ? mem_data_rd : '0;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: randomized scoreboard bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;
  localparam int TO = 4;
  logic        clk = 0, rst = 1;
  logic [31:0] mem_address, mem_data_wr, mem_data_rd;
  logic        mem_read, mem_write, mem_ready, bus_timeout;
  logic [3:0]  mem_mask;
  cpu_bus_arbiter_if ibus();
  cpu_bus_arbiter_if dbus();
  cpu_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ibus(ibus), .dbus(dbus),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_wr(mem_data_wr), .mem_mask(mem_mask), .mem_data_rd(mem_data_rd),
    .mem_ready(mem_ready), .bus_timeout(bus_timeout)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // memory responder: picks a latency per transfer, >TO means it never answers
  int          force_lat = -1;
  logic [31:0] force_data = 0;
  bit          stray_en = 0;
  int          cur_lat = 0, k = 0;
  logic [31:0] cur_data = 0;
  bit          was_strobe = 0;
  initial begin
    mem_ready = 0;
    mem_data_rd = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        was_strobe = 0;
        mem_ready = 0;
      end else begin
        if ((mem_read | mem_write) && !was_strobe) begin
          cur_lat  = force_lat >= 0 ? force_lat : int'($urandom_range(0, 6));
          cur_data = force_lat >= 0 ? force_data : $urandom;
          k = 0;
        end
        was_strobe = mem_read | mem_write;
        if (was_strobe) begin
          mem_ready = k == cur_lat;
          mem_data_rd = mem_ready ? cur_data : $urandom;
          k++;
        end else begin
          mem_ready = stray_en && $urandom_range(0, 7) == 0;
          mem_data_rd = $urandom;
        end
      end
    end
  end
  // reference model + monitor: expected response pushed at transfer start, popped on completion
  logic [31:0] dq[$], iq[$];
  bit mon_en = 0, p_strobe = 0, p_d = 0, p_i = 0, p_done = 0, busy_m = 0, own_d = 0, exp_to = 0;
  bit strobe, d_rq, i_rq, d_done, i_done, fin, exp_rd;
  int bk = 0, exp_len = 0;
  always @(negedge clk) begin
    strobe = mem_read | mem_write;
    d_rq = dbus.read | dbus.write;
    i_rq = ibus.read | ibus.write;
    if (rst || !mon_en) begin
      dq.delete(); iq.delete();
      busy_m = 0; p_strobe = 0; p_d = 0; p_i = 0; p_done = 0;
    end else begin
      if (p_done) chk("gap", strobe, 0);
      else if (!p_strobe) chk("accept", strobe, p_d | p_i);
      if (strobe && !p_strobe && (p_d | p_i)) begin
        own_d = p_d;
        busy_m = 1;
        bk = 0;
        exp_len = cur_lat <= TO ? cur_lat : TO;
        exp_to = cur_lat > TO;
        exp_rd = own_d ? dbus.read : 1'b1;
        chk("addr", mem_address, own_d ? dbus.address : ibus.address);
        chk("rd_strobe", mem_read, exp_rd);
        chk("wr_strobe", mem_write, own_d ? dbus.write : 1'b0);
        chk("mask", mem_mask, own_d ? dbus.mask : 4'hF);
        if (own_d && dbus.write) chk("wdata", mem_data_wr, dbus.data_wr);
        if (own_d) dq.push_back((exp_to || !exp_rd) ? 32'h0 : cur_data);
        else iq.push_back((exp_to || !exp_rd) ? 32'h0 : cur_data);
      end
      d_done = d_rq && !dbus.stall;
      i_done = i_rq && !ibus.stall;
      p_done = 0;
      if (busy_m) begin
        fin = bk == exp_len;
        chk("owner_done", own_d ? d_done : i_done, fin);
        chk("other_stalled", own_d ? i_done : d_done, 0);
        chk("timeout", bus_timeout, fin && exp_to);
        bk++;
        p_done = fin;
        if (fin) busy_m = 0;
      end else begin
        chk("idle_done", d_done | i_done, 0);
        chk("idle_timeout", bus_timeout, 0);
      end
      if (d_done) begin
        if (dq.size() == 0) chk("d_unexpected", 1, 0);
        else chk("d_data", dbus.data_rd, dq.pop_front());
      end else chk("d_data_idle", dbus.data_rd, 0);
      if (i_done) begin
        if (iq.size() == 0) chk("i_unexpected", 1, 0);
        else chk("i_data", ibus.data_rd, iq.pop_front());
      end else chk("i_data_idle", ibus.data_rd, 0);
      p_strobe = strobe;
      p_d = d_rq;
      p_i = i_rq;
    end
  end
  // master drivers: called at posedge+1, hold the request until stall drops, release next cycle
  task automatic d_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit wr);
    dbus.address = a; dbus.data_wr = d; dbus.mask = m; dbus.read = !wr; dbus.write = wr;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!dbus.stall) break;
      if (n == 59) chk("d_hang", 1, 0);
    end
    @(posedge clk); #1;
    dbus.read = 0; dbus.write = 0;
  endtask
  task automatic i_xfer(input logic [31:0] a);
    ibus.address = a; ibus.data_wr = $urandom; ibus.mask = 4'($urandom);
    ibus.read = 1; ibus.write = 1'($urandom_range(0, 1));
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (!ibus.stall) break;
      if (n == 59) chk("i_hang", 1, 0);
    end
    @(posedge clk); #1;
    ibus.read = 0; ibus.write = 0;
  endtask
  initial begin
    {dbus.address, dbus.data_wr, dbus.mask, dbus.read, dbus.write} = '0;
    {ibus.address, ibus.data_wr, ibus.mask, ibus.read, ibus.write} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_data_wr, 0);
    chk("rst_mask", mem_mask, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_timeout", bus_timeout, 0);
    chk("rst_stalls", {dbus.stall, ibus.stall}, 0);
    rst = 0;
    mon_en = 1;
    force_lat = 2; force_data = 32'h2408_0001;
    i_xfer(32'h1FC0_0000);
    force_lat = 1; force_data = 32'h1234_5678;
    fork
      d_xfer(32'h8000_0010, 32'hCAFE_F00D, 4'b0011, 1'b1);
      i_xfer(32'h1FC0_0004);
    join
    force_lat = 0; force_data = 32'h0BAD_BEEF;
    d_xfer(32'h0000_0100, 32'h0, 4'hF, 1'b0);
    d_xfer(32'h0000_0104, 32'h0, 4'hF, 1'b0);
    force_lat = 99;
    d_xfer(32'h0000_0200, 32'h0, 4'hF, 1'b0);
    stray_en = 1;
    repeat (4) @(posedge clk);
    #1;
    force_lat = -1;
    fork
      for (int n = 0; n < 150; n++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        d_xfer($urandom, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
      end
      for (int n = 0; n < 150; n++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        i_xfer($urandom);
      end
    join
    stray_en = 0;
    force_lat = 99;
    dbus.address = 32'h0000_0300; dbus.read = 1; dbus.write = 0; dbus.mask = 4'hF;
    @(posedge clk); #3;
    chk("pre_rst_busy", mem_read, 1);
    rst = 1;
    #1;
    chk("abort_strobes", {mem_read, mem_write}, 0);
    chk("abort_addr", mem_address, 0);
    chk("abort_mask", mem_mask, 0);
    chk("abort_stall", dbus.stall, 0);
    @(posedge clk); #1;
    dbus.read = 0;
    rst = 0;
    force_lat = 1; force_data = 32'h3C1D_0000;
    i_xfer(32'h1FC0_0100);
    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_bus_arbiter.md
# cpu_bus_arbiter

Shares the single external memory port between the CPU's instruction-fetch bus and the data bus driven by the memory stage. It latches one request at a time, runs it to completion against a variable-latency memory, and holds the losing requester stalled. The data bus has priority over instruction fetch. It sits between the CPU core's two `Bus_if` masters and the SoC memory/bridge.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for `mem_ready` before abandoning a transfer; 0 disables the timeout.

Ports:
- `clk` input 1: clock.
- `rst` input 1: asynchronous, active-high reset.
- `ibus` Bus_if.slave: instruction-fetch master, read-only; `write` is ignored.
- `dbus` Bus_if.slave: data master (memory stage); reads and writes.
- `mem_address` output 32: latched address.
- `mem_read` output 1: read strobe, held for the whole transfer.
- `mem_write` output 1: write strobe, held for the whole transfer.
- `mem_data_wr` output 32: latched write data.
- `mem_mask` output 4: latched byte enables.
- `mem_data_rd` input 32: read data, valid when `mem_ready` is high.
- `mem_ready` input 1: one-cycle completion pulse.
- `bus_timeout` output 1: one-cycle pulse when a transfer is abandoned.

## Operation
- A master requests when `read | write` is high, and holds all its signals until its `stall` goes low.
- FSM states: IDLE, D_BUSY, I_BUSY.
- **IDLE:**
  - If `dbus` is requesting, latch dbus address/data/mask/rd/wr and go to D_BUSY.
  - Otherwise, if `ibus` is requesting, latch ibus signals (write forced to 0, mask forced to 4'b1111) and go to I_BUSY.
  - Otherwise stay in IDLE.
  - Strict data priority; no fairness counter. While D_BUSY, the memory stage stalls the whole pipeline, so fetch cannot starve.
- **D_BUSY / I_BUSY:** drive `mem_*` from the latch; count wait cycles.
  - On `mem_ready`: return to IDLE and clear the latch strobes.
  - On count == TIMEOUT_CYCLES (when nonzero): return to IDLE and pulse `bus_timeout`.
- **Master stall:** `x.stall = x_requesting & ~(state == X_BUSY & (mem_ready | timeout_hit))`.
  - A requesting master is stalled in IDLE and while the other master is served.
- **Read data:** `x.data_rd = mem_data_rd` in the completion cycle of a read. On timeout, `data_rd` = 32'h0000_0000. At all other times it is 0.
- **Reset values:** state IDLE, `mem_address` 0, `mem_data_wr` 0, `mem_mask` 0, `mem_read` 0, `mem_write` 0, wait counter 0, `bus_timeout` 0, both stalls 0.
- **Reset mid-transfer:** the strobes drop asynchronously. The memory side must tolerate an aborted transfer; no completion is reported.
- **Simultaneous events:**
  - A request arriving in the same cycle as `mem_ready` for another master is not accepted until the next IDLE cycle.
  - `mem_ready` while in IDLE is ignored.
- The wait counter is 8 bits wide, or `$clog2(TIMEOUT_CYCLES+1)` bits in general. It saturates and never wraps.

## Timing
- Request in IDLE at cycle N: `mem_*` are valid from N+1 (registered).
- `mem_ready` at cycle M ≥ N+1: the master's `stall` is low and `data_rd` is valid in cycle M (combinational).
- The arbiter is back in IDLE at M+1. Minimum transfer is 2 cycles (accept, then ready).
- Back-to-back transfers from the same master: the next request is accepted at M+1, with memory strobes valid at M+2. One idle strobe cycle always separates transfers.
- Write completion reports exactly like a read; `data_rd` is 0.

## Structure
- Add `ArbState_t` (IDLE, D_BUSY, I_BUSY) to `cpu_defs.svh`.
- Add `MemPortReq_t` to `cpu_defs.svh`: address, data_wr, mask, read, write.
- The latch is one `MemPortReq_t` register.
- No sub-module is needed. The FSM, latch and wait counter live in one module of about 150–200 lines.

## Test plan
- **Single fetch:** ibus read 0x1FC0_0000, ready 3 cycles later → `mem_read` high for 3 cycles, ibus stall for 3 cycles, data_rd = 0x2408_0001 on the ready cycle.
- **Simultaneous requests:** dbus write 0x8000_0010 (mask 4'b0011) and ibus read together → dbus served first, `mem_write` with mask 4'b0011. ibus stays stalled until its own transfer completes two or more cycles later.
- **Back-to-back:** two dbus reads with zero memory wait → `mem_read` is high for 1 cycle each, with one gap cycle between them.
- **Timeout:** TIMEOUT_CYCLES = 4, `mem_ready` never asserted → `bus_timeout` pulses after 4 wait cycles, stall drops, data_rd = 0, state returns to IDLE.
- **Reset mid-transfer:** assert `rst` in D_BUSY → all `mem_*` outputs and stalls go to 0 in the same cycle. After release, a new ibus request completes normally.
- **Stray ready:** `mem_ready` pulse in IDLE → no stall change, no state change.
